// File: rtl/pwm_cmd_rx_pkg.sv
// Shared definitions for the PWM command receiver.
//   FRAME_LEN   : bits per serial command frame (dir, speed[3:0], parity)
//   rx_state_t  : receiver FSM state encoding
//   parity_ok() : even-parity check over a whole frame
package pwm_cmd_rx_pkg;

    localparam int unsigned FRAME_LEN = 6;
    localparam int unsigned CNT_W     = 3;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t StIdle  = 2'd0;
    localparam rx_state_t StRecv  = 2'd1;
    localparam rx_state_t StCheck = 2'd2;

    // Even parity: the XOR of every bit in the frame, parity bit included, is 0.
    function automatic logic parity_ok(input logic [FRAME_LEN-1:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/pwm_cmd_rx_sync_edge.sv
// N-stage synchroniser with a one-cycle rising-edge pulse on the synced value.
//   clk  : system clock
//   rst  : synchronous reset, active-high (clears every stage)
//   d    : asynchronous input
//   rise : one-cycle pulse when the synced value goes 0 -> 1
module pwm_cmd_rx_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_cmd_rx.sv
// Serial command front-end for the sine-PWM phase driver.
// Synchronises the async freq/f_en lines, deframes 6-bit commands (dir, speed[3:0], even
// parity, MSB first), and ramps the applied speed/direction toward the accepted target.
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   en    : block enable; receiver, timeout and ramp divider hold while low
//   freq  : serial data (async), sampled on a rising f_en
//   f_en  : serial bit strobe (async)
//   speed : applied (ramped) speed
//   dir   : applied direction
//   upd   : one-cycle pulse when speed or dir changed
//   err   : one-cycle pulse on parity error or mid-frame timeout
//   busy  : frame in progress or applied value not yet at target
module pwm_cmd_rx
    import pwm_cmd_rx_pkg::*;
#(
    parameter int unsigned BITS        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned RAMP_DIV    = 16384
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            freq,
    input  logic            f_en,
    output logic [BITS-1:0] speed,
    output logic            dir,
    output logic            upd,
    output logic            err,
    output logic            busy
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DIV_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [BITS-1:0]  SPD_MAX  = {BITS{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    // Synchronisers
    logic                   fen_rise;
    logic [SYNC_STAGES-1:0] freq_sync_q;
    logic                   freq_s;

    pwm_cmd_rx_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_fen_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (f_en),
        .rise (fen_rise)
    );

    // freq uses the same depth as f_en so the sampled bit lines up with the strobe edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_sync_q <= '0;
        end else begin
            freq_sync_q <= {freq_sync_q[SYNC_STAGES-2:0], freq};
        end
    end

    assign freq_s = freq_sync_q[SYNC_STAGES-1];

    // State
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BITS-1:0]        tgt_speed_q, tgt_speed_d;
    logic                   tgt_dir_q, tgt_dir_d;
    logic [BITS-1:0]        speed_q, speed_d;
    logic                   dir_q, dir_d;
    logic                   upd_q, upd_d;
    logic                   err_q, err_d;
    logic                   tick;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        div_d       = div_q;
        tgt_speed_d = tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;
        speed_d     = speed_q;
        dir_d       = dir_q;
        upd_d       = 1'b0;
        err_d       = 1'b0;
        tick        = 1'b0;

        if (en) begin
            // Receiver
            unique case (state_q)
                StIdle: begin
                    if (fen_rise) begin
                        shift_d = {shift_q[FRAME_LEN-2:0], freq_s};
                        cnt_d   = CNT_W'(1);
                        tmo_d   = '0;
                        state_d = StRecv;
                    end
                end
                StRecv: begin
                    if (fen_rise) begin
                        shift_d = {shift_q[FRAME_LEN-2:0], freq_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                        tmo_d   = '0;
                        if (cnt_q == CNT_LAST) begin
                            state_d = StCheck;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                StCheck: begin
                    // Any bit event landing in this cycle is dropped by design.
                    if (parity_ok(shift_q)) begin
                        tgt_dir_d   = shift_q[FRAME_LEN-1];
                        tgt_speed_d = BITS'(shift_q[FRAME_LEN-2:1]);
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            endcase

            // Ramp divider and single-step ramp
            tick  = (div_q == DIV_LAST);
            div_d = tick ? '0 : div_q + DIV_W'(1);

            if (tick) begin
                if (tgt_dir_q == dir_q) begin
                    if (speed_q < tgt_speed_q && speed_q != SPD_MAX) begin
                        speed_d = speed_q + BITS'(1);
                        upd_d   = 1'b1;
                    end else if (speed_q > tgt_speed_q && speed_q != '0) begin
                        speed_d = speed_q - BITS'(1);
                        upd_d   = 1'b1;
                    end
                end else if (speed_q != '0) begin
                    // Reversal: spin down to zero before flipping direction.
                    speed_d = speed_q - BITS'(1);
                    upd_d   = 1'b1;
                end else begin
                    dir_d = ~dir_q;
                    upd_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            div_q       <= '0;
            tgt_speed_q <= '0;
            tgt_dir_q   <= 1'b0;
            speed_q     <= '0;
            dir_q       <= 1'b0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            div_q       <= div_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

    assign speed = speed_q;
    assign dir   = dir_q;
    assign upd   = upd_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle) || (speed_q != tgt_speed_q) || (dir_q != tgt_dir_q);

endmodule

// File: tb/tb_pwm_cmd_rx.sv
// Self-checking bench for pwm_cmd_rx: expected (dir, speed) steps are queued when a frame
// is sent and popped as each upd pulse appears.
module tb_pwm_cmd_rx;

    localparam int unsigned BITS        = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 16;
    localparam int unsigned RAMP_DIV    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            freq;
    logic            f_en;
    logic [BITS-1:0] speed;
    logic            dir;
    logic            upd;
    logic            err;
    logic            busy;

    pwm_cmd_rx #(
        .BITS        (BITS),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT),
        .RAMP_DIV    (RAMP_DIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .freq  (freq),
        .f_en  (f_en),
        .speed (speed),
        .dir   (dir),
        .upd   (upd),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned upd_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned cyc = 0;
    int unsigned last_upd_cyc = 0;

    logic [BITS:0]   exp_q[$];  // {dir, speed} after each expected step
    logic [BITS:0]   mon_e;
    logic            m_dir;
    logic [BITS-1:0] m_spd;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (upd === 1'b1) begin
            upd_cnt++;
            if (last_upd_cyc != 0 && cyc - last_upd_cyc < 10)
                check("step_gap", cyc - last_upd_cyc, RAMP_DIV);
            last_upd_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("upd_speed", speed, mon_e[BITS-1:0]);
                check("upd_dir", dir, mon_e[BITS]);
            end
        end
    end

    // Model of the ramp from the current model state to a new target.
    task automatic push_ramp(input logic tdir, input logic [BITS-1:0] tspd);
        while (m_dir != tdir || m_spd != tspd) begin
            if (m_dir == tdir) m_spd = (m_spd < tspd) ? m_spd + 1'b1 : m_spd - 1'b1;
            else if (m_spd != 0) m_spd = m_spd - 1'b1;
            else m_dir = ~m_dir;
            exp_q.push_back({m_dir, m_spd});
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        freq = b;
        repeat (2) @(negedge clk);
        f_en = 1'b1;
        repeat (3) @(negedge clk);
        f_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic d, input logic [3:0] s, input logic p,
                              input logic valid);
        if (valid) push_ramp(d, BITS'(s));
        send_bit(d);
        for (int i = 3; i >= 0; i--) send_bit(s[i]);
        send_bit(p);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_low"}, busy, 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned u0;
        int unsigned e0;
        int n;

        rst  = 1'b1;
        en   = 1'b1;
        freq = 1'b0;
        f_en = 1'b0;
        m_dir = 1'b0;
        m_spd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_speed", speed, 0);
        check("rst_dir", dir, 0);
        check("rst_busy", busy, 0);
        check("rst_upd", upd, 0);
        check("rst_err", err, 0);

        // Ramp 0 -> 10
        u0 = upd_cnt;
        send_frame(1'b0, 4'd10, 1'b0, 1'b1);
        wait_idle("t1");
        check("t1_upd_count", upd_cnt - u0, 10);
        check("t1_speed", speed, 10);

        // Bad parity
        u0 = upd_cnt;
        e0 = err_cnt;
        send_frame(1'b0, 4'd10, 1'b1, 1'b0);
        wait_idle("t2");
        check("t2_err_count", err_cnt - e0, 1);
        check("t2_upd_count", upd_cnt - u0, 0);
        check("t2_speed", speed, 10);

        // Down to 3, then reverse at the same speed
        send_frame(1'b0, 4'd3, 1'b0, 1'b1);
        wait_idle("t3a");
        check("t3a_speed", speed, 3);
        u0 = upd_cnt;
        send_frame(1'b1, 4'd3, 1'b1, 1'b1);
        wait_idle("t3");
        check("t3_upd_count", upd_cnt - u0, 7);
        check("t3_dir", dir, 1);
        check("t3_speed", speed, 3);

        // Partial frame timeout
        e0 = err_cnt;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (30) @(negedge clk);
        check("t4_err_count", err_cnt - e0, 1);
        check("t4_busy", busy, 0);

        // Next frame accepted; pause the ramp at speed 5
        send_frame(1'b1, 4'd9, 1'b1, 1'b1);
        n = 0;
        while (speed != 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach", speed, 5);
        en = 1'b0;
        @(negedge clk);
        u0 = upd_cnt;
        repeat (20) @(negedge clk);
        check("t5_hold_speed", speed, 5);
        check("t5_hold_upd", upd_cnt - u0, 0);
        en = 1'b1;
        wait_idle("t5");
        check("t5_speed", speed, 9);
        check("t5_dir", dir, 1);

        // Reset during bit 4 of a frame while at speed 7
        send_frame(1'b1, 4'd7, 1'b0, 1'b1);
        wait_idle("t6a");
        check("t6a_speed", speed, 7);
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        freq = 1'b0;
        repeat (2) @(negedge clk);
        f_en = 1'b1;
        @(negedge clk);
        rst  = 1'b1;
        f_en = 1'b0;
        exp_q.delete();
        m_dir = 1'b0;
        m_spd = '0;
        @(negedge clk);
        check("t6_speed", speed, 0);
        check("t6_dir", dir, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_err_count", err_cnt - e0, 0);
        check("t6_busy_after", busy, 0);

        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
